// File: rtl/pipeline_hazard_unit_pkg.sv
// pipeline_hazard_unit_pkg: forward codes, FSM encoding and field widths shared by the hazard unit.
package pipeline_hazard_unit_pkg;
   localparam int FWD_W = 2;
   localparam int CNT_W = 4;
   localparam logic [FWD_W-1:0] FWD_REG      = 2'd0;
   localparam logic [FWD_W-1:0] FWD_EXE      = 2'd1;
   localparam logic [FWD_W-1:0] FWD_MEM_ALU  = 2'd2;
   localparam logic [FWD_W-1:0] FWD_MEM_LOAD = 2'd3;
   typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;
   // A load still in EXE has no data yet, so an EXE match on a load selects the regfile
   function automatic logic [FWD_W-1:0] fwd_sel(input logic m_exe, ld_exe, m_mem, ld_mem);
      return m_exe ? (ld_exe ? FWD_REG : FWD_EXE) : m_mem ? (ld_mem ? FWD_MEM_LOAD : FWD_MEM_ALU) : FWD_REG;
   endfunction
endpackage

// File: rtl/pipeline_hazard_unit_src_cmp.sv
// hazard_src_cmp: compares one ID source register against the EXE and MEM destination trackers.
module hazard_src_cmp
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              used,
   input  logic              exe_v,
   input  logic              exe_wen,
   input  logic [ADDR_W-1:0] exe_waddr,
   input  logic              mem_v,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic              mem_load,
   output logic              match_exe,
   output logic              match_mem,
   output logic              mem_is_load
);
   logic live;
   assign live = used && addr != '0;
   assign match_exe = live && exe_v && exe_wen && exe_waddr == addr;
   assign match_mem = live && mem_v && mem_wen && mem_waddr == addr;
   assign mem_is_load = match_mem && mem_load;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush/forward control for a 5-stage MIPS pipeline with multi-cycle loads.
// Define HAZARD_STATS_EN to add saturating stall/flush/wait event counters.
module pipeline_hazard_unit
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int LOAD_LAT   = 1,
   parameter int DELAY_SLOT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs_addr,
   input  logic [ADDR_W-1:0] id_rt_addr,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wen,
   input  logic [ADDR_W-1:0] id_waddr,
   input  logic              id_is_load,
   input  logic              id_is_store,
   input  logic              id_is_branch,
   input  logic              branch_taken,
   output logic              if_en,
   output logic              id_en,
   output logic              exe_en,
   output logic              mem_en,
   output logic              wb_en,
   output logic              if_rst,
   output logic              id_rst,
   output logic              exe_rst,
   output logic              mem_rst,
   output logic              wb_rst,
   output logic [FWD_W-1:0]  fwd_rs,
   output logic [FWD_W-1:0]  fwd_rt,
   output logic              fwd_mem
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count,
   output logic [31:0]       wait_cycles
`endif
);
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              exe_v, exe_wen, exe_load, mem_v, mem_wen, mem_load;
   logic [ADDR_W-1:0] exe_waddr, mem_waddr;
   logic              rs_exe, rs_mem, rs_mem_ld, rt_exe, rt_mem, rt_mem_ld;
   logic              waiting, stall, flush, take;
   logic [4:0]        en, clr;

   hazard_src_cmp #(.ADDR_W(ADDR_W)) u_rs (
      .addr(id_rs_addr), .used(id_rs_used),
      .exe_v(exe_v), .exe_wen(exe_wen), .exe_waddr(exe_waddr),
      .mem_v(mem_v), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_load(mem_load),
      .match_exe(rs_exe), .match_mem(rs_mem), .mem_is_load(rs_mem_ld)
   );

   hazard_src_cmp #(.ADDR_W(ADDR_W)) u_rt (
      .addr(id_rt_addr), .used(id_rt_used),
      .exe_v(exe_v), .exe_wen(exe_wen), .exe_waddr(exe_waddr),
      .mem_v(mem_v), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_load(mem_load),
      .match_exe(rt_exe), .match_mem(rt_mem), .mem_is_load(rt_mem_ld)
   );

   assign waiting = state == ST_MEM_WAIT;
   // Store data on rt can be picked up from MEM/WB one cycle later, so that case never stalls
   assign stall = id_is_branch ? (rs_exe || rs_mem || rt_exe || rt_mem)
                               : exe_load && (rs_exe || (rt_exe && !id_is_store));
   assign flush = branch_taken && !stall && DELAY_SLOT == 0;
   assign take = id_valid && !stall;

   assign en  = (rst || !cpu_en) ? 5'b00000 : waiting ? 5'b00001 : stall ? 5'b00111 : 5'b11111;
   assign clr = rst ? 5'b11111 : !cpu_en ? 5'b00000 : waiting ? 5'b00001 :
                stall ? 5'b00100 : flush ? 5'b01000 : 5'b00000;
   assign {if_en, id_en, exe_en, mem_en, wb_en} = en;
   assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = clr;

   assign fwd_rs  = (rst || id_is_branch) ? FWD_REG : fwd_sel(rs_exe, exe_load, rs_mem, rs_mem_ld);
   assign fwd_rt  = (rst || id_is_branch) ? FWD_REG : fwd_sel(rt_exe, exe_load, rt_mem, rt_mem_ld);
   assign fwd_mem = !rst && !id_is_branch && id_is_store && rt_exe && exe_load && !rs_exe;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         cnt       <= '0;
         {exe_v, exe_wen, exe_load, mem_v, mem_wen, mem_load} <= '0;
         exe_waddr <= '0;
         mem_waddr <= '0;
      end else if (cpu_en) begin
         if (waiting) begin
            if (cnt == '0) state <= ST_RUN;
            else cnt <= cnt - 1'b1;
         end else begin
            {mem_v, mem_wen, mem_load} <= {exe_v, exe_wen, exe_load};
            mem_waddr <= exe_waddr;
            exe_v     <= take;
            exe_wen   <= take && id_wen;
            exe_load  <= take && id_is_load;
            exe_waddr <= take ? id_waddr : '0;
            if (mem_v && mem_load && LOAD_LAT > 1) begin
               state <= ST_MEM_WAIT;
               cnt   <= CNT_W'(LOAD_LAT - 2);
            end
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         wait_cycles  <= '0;
      end else if (cpu_en) begin
         if (!waiting && stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
         if (!waiting && flush && flush_count != '1) flush_count <= flush_count + 1'b1;
         if (waiting && wait_cycles != '1) wait_cycles <= wait_cycles + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed vectors plus random stimulus checked against an instruction-level model.
module tb_pipeline_hazard_unit;
   typedef struct packed {
      logic rst, cpu_en, valid;
      logic [4:0] rs, rt;
      logic rsu, rtu, wen;
      logic [4:0] waddr;
      logic load, store, branch, taken;
   } in_t;
   typedef struct packed {
      logic [4:0] en, clr;
      logic [1:0] frs, frt;
      logic fm;
   } out_t;
   typedef struct {in_t i; out_t e;} vec_t;
   typedef struct {logic v, wen; logic [4:0] wa; logic ld;} inst_t;
   typedef struct {inst_t ex, mem; int wait_left;} mst_t;

   localparam logic [4:0] ALL = 5'b11111, STE = 5'b00111, STC = 5'b00100, WT = 5'b00001, FL = 5'b01000, NO = 5'b00000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t cur;
   out_t o0, o1;
   logic if_en0, id_en0, exe_en0, mem_en0, wb_en0, if_rst0, id_rst0, exe_rst0, mem_rst0, wb_rst0, fwd_mem0;
   logic if_en1, id_en1, exe_en1, mem_en1, wb_en1, if_rst1, id_rst1, exe_rst1, mem_rst1, wb_rst1, fwd_mem1;
   logic [1:0] fwd_rs0, fwd_rt0, fwd_rs1, fwd_rt1;
   int checks = 0, errors = 0;
   mst_t m0, m1;
   vec_t tbl[$];

   pipeline_hazard_unit #(.ADDR_W(5), .LOAD_LAT(4), .DELAY_SLOT(0)) dut0 (
      .clk(clk), .rst(cur.rst), .cpu_en(cur.cpu_en), .id_valid(cur.valid),
      .id_rs_addr(cur.rs), .id_rt_addr(cur.rt), .id_rs_used(cur.rsu), .id_rt_used(cur.rtu),
      .id_wen(cur.wen), .id_waddr(cur.waddr), .id_is_load(cur.load), .id_is_store(cur.store),
      .id_is_branch(cur.branch), .branch_taken(cur.taken),
      .if_en(if_en0), .id_en(id_en0), .exe_en(exe_en0), .mem_en(mem_en0), .wb_en(wb_en0),
      .if_rst(if_rst0), .id_rst(id_rst0), .exe_rst(exe_rst0), .mem_rst(mem_rst0), .wb_rst(wb_rst0),
      .fwd_rs(fwd_rs0), .fwd_rt(fwd_rt0), .fwd_mem(fwd_mem0)
   );

   pipeline_hazard_unit #(.ADDR_W(5), .LOAD_LAT(1), .DELAY_SLOT(1)) dut1 (
      .clk(clk), .rst(cur.rst), .cpu_en(cur.cpu_en), .id_valid(cur.valid),
      .id_rs_addr(cur.rs), .id_rt_addr(cur.rt), .id_rs_used(cur.rsu), .id_rt_used(cur.rtu),
      .id_wen(cur.wen), .id_waddr(cur.waddr), .id_is_load(cur.load), .id_is_store(cur.store),
      .id_is_branch(cur.branch), .branch_taken(cur.taken),
      .if_en(if_en1), .id_en(id_en1), .exe_en(exe_en1), .mem_en(mem_en1), .wb_en(wb_en1),
      .if_rst(if_rst1), .id_rst(id_rst1), .exe_rst(exe_rst1), .mem_rst(mem_rst1), .wb_rst(wb_rst1),
      .fwd_rs(fwd_rs1), .fwd_rt(fwd_rt1), .fwd_mem(fwd_mem1)
   );

   assign o0 = {if_en0, id_en0, exe_en0, mem_en0, wb_en0, if_rst0, id_rst0, exe_rst0, mem_rst0, wb_rst0, fwd_rs0, fwd_rt0, fwd_mem0};
   assign o1 = {if_en1, id_en1, exe_en1, mem_en1, wb_en1, if_rst1, id_rst1, exe_rst1, mem_rst1, wb_rst1, fwd_rs1, fwd_rt1, fwd_mem1};

   function automatic in_t nop();
      in_t x = '0;
      x.cpu_en = 1'b1;
      return x;
   endfunction

   function automatic in_t mk(input logic [4:0] rs, rt, wa, input logic rsu, rtu, wen, ld, st, br, tk);
      in_t x = nop();
      x.valid = 1'b1; x.rs = rs; x.rt = rt; x.waddr = wa; x.rsu = rsu; x.rtu = rtu;
      x.wen = wen; x.load = ld; x.store = st; x.branch = br; x.taken = tk;
      return x;
   endfunction

   function automatic in_t alu(input logic [4:0] rd, rs, rt); return mk(rs, rt, rd, 1, 1, 1, 0, 0, 0, 0); endfunction
   function automatic in_t lw(input logic [4:0] rd, rs);      return mk(rs, 0, rd, 1, 0, 1, 1, 0, 0, 0); endfunction
   function automatic in_t sw(input logic [4:0] rt, rs);      return mk(rs, rt, 0, 1, 1, 0, 0, 1, 0, 0); endfunction
   function automatic in_t beq(input logic [4:0] rs, rt, input logic tk); return mk(rs, rt, 0, 1, 1, 0, 0, 0, 1, tk); endfunction
   function automatic in_t rst_in(); in_t x = nop(); x.rst = 1'b1; return x; endfunction
   function automatic in_t off(input in_t x); in_t y = x; y.cpu_en = 1'b0; return y; endfunction

   function automatic vec_t vv(input in_t i, input logic [4:0] en, clr, input logic [1:0] frs, frt, input logic fm);
      vec_t v;
      v.i = i;
      v.e = {en, clr, frs, frt, fm};
      return v;
   endfunction

   // Reference model: an instruction sitting in EXE/MEM and a count of MEM wait cycles left
   function automatic bit produces(input inst_t s, input logic used, input logic [4:0] a);
      return used && a != 0 && s.v && s.wen && s.wa == a;
   endfunction

   function automatic logic [1:0] src_fwd(input mst_t m, input bit in_exe, input bit in_mem);
      if (in_exe) return m.ex.ld ? 2'd0 : 2'd1;
      if (in_mem) return m.mem.ld ? 2'd3 : 2'd2;
      return 2'd0;
   endfunction

   function automatic bit must_stall(input mst_t m, input in_t i);
      bit rse = produces(m.ex, i.rsu, i.rs), rte = produces(m.ex, i.rtu, i.rt);
      bit rsm = produces(m.mem, i.rsu, i.rs), rtm = produces(m.mem, i.rtu, i.rt);
      if (i.branch) return rse || rte || rsm || rtm;
      return m.ex.ld && (rse || (rte && !i.store));
   endfunction

   function automatic out_t ref_out(input mst_t m, input in_t i, input int ds);
      out_t o = '0;
      bit rse = produces(m.ex, i.rsu, i.rs), rte = produces(m.ex, i.rtu, i.rt);
      bit rsm = produces(m.mem, i.rsu, i.rs), rtm = produces(m.mem, i.rtu, i.rt);
      bit st = must_stall(m, i);
      if (i.rst) begin
         o.clr = ALL;
         return o;
      end
      if (!i.branch) begin
         o.frs = src_fwd(m, rse, rsm);
         o.frt = src_fwd(m, rte, rtm);
         o.fm = i.store && rte && m.ex.ld && !rse;
      end
      if (!i.cpu_en) return o;
      if (m.wait_left > 0) begin
         o.en = WT; o.clr = WT;
      end else if (st) begin
         o.en = STE; o.clr = STC;
      end else begin
         o.en = ALL;
         if (i.taken && ds == 0) o.clr = FL;
      end
      return o;
   endfunction

   function automatic mst_t ref_step(input mst_t m, input in_t i, input int ll);
      mst_t n = m;
      inst_t empty = '{0, 0, 0, 0};
      if (i.rst) begin
         n.ex = empty; n.mem = empty; n.wait_left = 0;
      end else if (!i.cpu_en) begin
         n = m;
      end else if (m.wait_left > 0) begin
         n.wait_left = m.wait_left - 1;
      end else begin
         n.mem = m.ex;
         n.ex = (must_stall(m, i) || !i.valid) ? empty : '{1'b1, i.wen, i.waddr, i.load};
         if (m.mem.v && m.mem.ld && ll > 1) n.wait_left = ll - 1;
      end
      return n;
   endfunction

   task automatic check(input out_t got, input out_t exp, input string name, input int idx);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s #%0d: got en=%b rst=%b fwd_rs=%0d fwd_rt=%0d fwd_mem=%b, expected en=%b rst=%b fwd_rs=%0d fwd_rt=%0d fwd_mem=%b",
                  name, idx, got.en, got.clr, got.frs, got.frt, got.fm, exp.en, exp.clr, exp.frs, exp.frt, exp.fm);
      end
   endtask

   task automatic run(input in_t v, input bit has_exp, input out_t exp, input string name, input int idx);
      cur = v;
      @(negedge clk);
      check(o0, ref_out(m0, v, 0), "model_dut0", idx);
      check(o1, ref_out(m1, v, 1), "model_dut1", idx);
      if (has_exp) check(o0, exp, name, idx);
      @(posedge clk);
      m0 = ref_step(m0, v, 4);
      m1 = ref_step(m1, v, 1);
      #1;
   endtask

   initial begin
      in_t r;
      m0 = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, 0};
      m1 = m0;
      cur = rst_in();
      @(posedge clk);
      #1;
      tbl.push_back(vv(rst_in(),         NO,  ALL, 0, 0, 0));
      tbl.push_back(vv(alu(3, 1, 2),     ALL, NO,  0, 0, 0));
      tbl.push_back(vv(alu(4, 3, 5),     ALL, NO,  1, 0, 0));
      tbl.push_back(vv(alu(6, 3, 0),     ALL, NO,  2, 0, 0));
      tbl.push_back(vv(lw(3, 1),         ALL, NO,  0, 0, 0));
      tbl.push_back(vv(alu(4, 3, 3),     STE, STC, 0, 0, 0));
      tbl.push_back(vv(alu(4, 3, 3),     ALL, NO,  3, 3, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            ALL, NO,  0, 0, 0));
      tbl.push_back(vv(lw(3, 1),         ALL, NO,  0, 0, 0));
      tbl.push_back(vv(sw(3, 1),         ALL, NO,  0, 0, 1));
      tbl.push_back(vv(nop(),            ALL, NO,  0, 0, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            WT,  WT,  0, 0, 0));
      tbl.push_back(vv(nop(),            ALL, NO,  0, 0, 0));
      tbl.push_back(vv(alu(3, 1, 0),     ALL, NO,  0, 0, 0));
      tbl.push_back(vv(beq(3, 0, 1),     STE, STC, 0, 0, 0));
      tbl.push_back(vv(beq(3, 0, 1),     STE, STC, 0, 0, 0));
      tbl.push_back(vv(beq(3, 0, 1),     ALL, FL,  0, 0, 0));
      tbl.push_back(vv(off(nop()),       NO,  NO,  0, 0, 0));
      foreach (tbl[k]) run(tbl[k].i, 1'b1, tbl[k].e, "vec", k);
      // reset in the middle of a load wait, then a cpu_en freeze with a live EXE producer
      run(lw(5, 1),           1'b1, {ALL, NO, 2'd0, 2'd0, 1'b0}, "seq_lw", 0);
      run(nop(),              1'b1, {ALL, NO, 2'd0, 2'd0, 1'b0}, "seq_lw_exe", 1);
      run(nop(),              1'b1, {ALL, NO, 2'd0, 2'd0, 1'b0}, "seq_lw_mem", 2);
      run(nop(),              1'b1, {WT, WT, 2'd0, 2'd0, 1'b0},  "seq_wait", 3);
      run(rst_in(),           1'b1, {NO, ALL, 2'd0, 2'd0, 1'b0}, "seq_rst_in_wait", 4);
      run(nop(),              1'b1, {ALL, NO, 2'd0, 2'd0, 1'b0}, "seq_back_to_run", 5);
      run(alu(7, 1, 2),       1'b1, {ALL, NO, 2'd0, 2'd0, 1'b0}, "seq_prod", 6);
      run(off(alu(8, 7, 0)),  1'b1, {NO, NO, 2'd1, 2'd0, 1'b0},  "seq_cpu_off", 7);
      run(alu(8, 7, 0),       1'b1, {ALL, NO, 2'd1, 2'd0, 1'b0}, "seq_frozen_trk", 8);
      for (int n = 0; n < 3000; n++) begin
         r = nop();
         r.rst    = $urandom_range(0, 63) == 0;
         r.cpu_en = $urandom_range(0, 7) != 0;
         r.valid  = $urandom_range(0, 7) != 0;
         r.rs     = 5'($urandom_range(0, 3));
         r.rt     = 5'($urandom_range(0, 3));
         r.waddr  = 5'($urandom_range(0, 3));
         r.rsu    = $urandom_range(0, 3) != 0;
         r.rtu    = $urandom_range(0, 1) == 1;
         r.wen    = $urandom_range(0, 3) != 0;
         r.load   = $urandom_range(0, 3) == 0;
         r.store  = $urandom_range(0, 4) == 0;
         r.branch = $urandom_range(0, 5) == 0;
         r.taken  = $urandom_range(0, 3) == 0;
         run(r, 1'b0, '0, "rand", n);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
